// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one registered word RAM between a CPU bus and a video fetcher.
// Video has priority, but a CPU that waited through a video fetch is served next.
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_dtack,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_ack,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_ub,
  output logic        ram_lb,
  input  logic [15:0] ram_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, CAP = 2'd2, HOLD = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        owner_vid_q, owner_vid_d;
  logic        wr_q, wr_d;
  logic        fair_q, fair_d;
  logic        cpu_dtack_q, cpu_dtack_d;
  logic        vid_ack_q, vid_ack_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_ub_q, ram_ub_d;
  logic        ram_lb_q, ram_lb_d;
  logic [13:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_din_q, ram_din_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_data_q, vid_data_d;

  // Next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    owner_vid_d = owner_vid_q;
    wr_d        = wr_q;
    fair_d      = fair_q;
    cpu_dtack_d = cpu_dtack_q;
    vid_ack_d   = 1'b0;
    ram_we_d    = ram_we_q;
    ram_ub_d    = ram_ub_q;
    ram_lb_d    = ram_lb_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    case (state_q)
      IDLE: begin
        cpu_dtack_d = 1'b0;
        // A pending CPU that was passed over by the last video fetch wins this slot
        if (vid_req && !(fair_q && cpu_req)) begin
          owner_vid_d = 1'b1;
          wr_d        = 1'b0;
          fair_d      = 1'b0;
          ram_addr_d  = vid_addr;
          ram_we_d    = 1'b0;
          ram_ub_d    = 1'b1;
          ram_lb_d    = 1'b1;
          state_d     = ACC;
        end else if (cpu_req) begin
          owner_vid_d = 1'b0;
          wr_d        = ~cpu_rw;
          fair_d      = 1'b0;
          ram_addr_d  = cpu_addr;
          if (!cpu_rw) begin
            ram_we_d  = 1'b1;
            ram_din_d = cpu_wdata;
            ram_ub_d  = cpu_uds;
            ram_lb_d  = cpu_lds;
          end else begin
            ram_we_d  = 1'b0;
            ram_ub_d  = 1'b1;
            ram_lb_d  = 1'b1;
          end
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (wr_q) begin
          ram_we_d    = 1'b0;
          cpu_dtack_d = 1'b1;
          state_d     = HOLD;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        if (owner_vid_q) begin
          vid_data_d = ram_dout;
          vid_ack_d  = 1'b1;
          fair_d     = cpu_req;
          state_d    = IDLE;
        end else begin
          cpu_rdata_d = ram_dout;
          cpu_dtack_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cpu_req) begin
          cpu_dtack_d = 1'b1;
        end else begin
          cpu_dtack_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cpu_dtack_d = 1'b0;
        ram_we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_vid_q <= 1'b0;
      wr_q        <= 1'b0;
      fair_q      <= 1'b0;
      cpu_dtack_q <= 1'b0;
      vid_ack_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_ub_q    <= 1'b0;
      ram_lb_q    <= 1'b0;
      ram_addr_q  <= 14'd0;
      ram_din_q   <= 16'd0;
      cpu_rdata_q <= 16'd0;
      vid_data_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_vid_q <= owner_vid_d;
      wr_q        <= wr_d;
      fair_q      <= fair_d;
      cpu_dtack_q <= cpu_dtack_d;
      vid_ack_q   <= vid_ack_d;
      ram_we_q    <= ram_we_d;
      ram_ub_q    <= ram_ub_d;
      ram_lb_q    <= ram_lb_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign cpu_dtack = cpu_dtack_q;
  assign vid_ack   = vid_ack_q;
  assign ram_we    = ram_we_q;
  assign ram_ub    = ram_ub_q;
  assign ram_lb    = ram_lb_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_data  = vid_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: byte-lane RAM model, associative-array memory
// reference, table-driven CPU vectors, hand-written corner sequences and random traffic.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, cpu_uds, cpu_lds;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_dtack;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_ack;
  logic        ram_we, ram_ub, ram_lb;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_dtack(cpu_dtack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_ub(ram_ub), .ram_lb(ram_lb), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Registered word RAM with byte lanes
  logic [15:0] mem [0:16383] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_ub) mem[ram_addr][15:8] <= ram_din[15:8];
      if (ram_lb) mem[ram_addr][7:0]  <= ram_din[7:0];
    end
    ram_dout <= mem[ram_addr];
  end

  // Reference memory: contents the CPU is entitled to see back
  logic [15:0] model_mem [int];

  function automatic logic [15:0] model_rd(input logic [13:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    else return 16'h0000;
  endfunction

  task automatic model_wr(input logic [13:0] a, input logic [15:0] d, input logic u, input logic l);
    logic [15:0] w;
    w = model_rd(a);
    if (u) w[15:8] = d[15:8];
    if (l) w[7:0]  = d[7:0];
    model_mem[int'(a)] = w;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // All tasks start and end at #1 after a rising edge
  task automatic cpu_write(input logic [13:0] a, input logic [15:0] d, input logic u,
                           input logic l, input int hold_extra);
    int lat, we_cnt;
    logic got, held;
    cpu_addr = a; cpu_wdata = d; cpu_uds = u; cpu_lds = l; cpu_rw = 1'b0; cpu_req = 1'b1;
    lat = 0; we_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ram_we) we_cnt++;
      if (cpu_dtack) got = 1'b1;
    end
    check("wr_dtack_latency", got ? lat : 99, 2);
    check("wr_we_one_cycle", we_cnt, 1);
    held = 1'b1;
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
      if (!cpu_dtack || ram_we) held = 1'b0;
    end
    check("wr_dtack_held", held, 1'b1);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("wr_dtack_release", cpu_dtack, 1'b0);
    model_wr(a, d, u, l);
  endtask

  task automatic cpu_read(input logic [13:0] a, input int hold_extra);
    int lat;
    logic got;
    cpu_addr = a; cpu_rw = 1'b1; cpu_req = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_dtack) got = 1'b1;
    end
    check("rd_dtack_latency", got ? lat : 99, 3);
    check("rd_data", cpu_rdata, model_rd(a));
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rd_dtack_release", cpu_dtack, 1'b0);
    check("rd_data_hold", cpu_rdata, model_rd(a));
  endtask

  task automatic vid_fetch(input logic [13:0] a);
    int lat;
    logic got;
    vid_addr = a; vid_req = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (vid_ack) got = 1'b1;
    end
    vid_req = 1'b0;
    check("vid_ack_latency", got ? lat : 99, 3);
    check("vid_data", vid_data, model_rd(a));
    @(posedge clk); #1;
    check("vid_ack_pulse", vid_ack, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        uds;
    logic        lds;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    string order;
    int edge_no, last_ack, ack_cnt, gap_bad, ack_seen, dt_seen;
    logic [15:0] vdat, cdat;
    logic cdone;
    logic [13:0] va;
    logic [13:0] vaddrs [6];

    vecs[0] = '{addr: 14'h0010, wdata: 16'h1234, uds: 1'b1, lds: 1'b1, exp_rd: 16'h1234};
    vecs[1] = '{addr: 14'h0010, wdata: 16'hABCD, uds: 1'b1, lds: 1'b0, exp_rd: 16'hAB34};
    vecs[2] = '{addr: 14'h0010, wdata: 16'h5555, uds: 1'b0, lds: 1'b0, exp_rd: 16'hAB34};
    vecs[3] = '{addr: 14'h0020, wdata: 16'hBEEF, uds: 1'b0, lds: 1'b1, exp_rd: 16'h00EF};
    vecs[4] = '{addr: 14'h3FFF, wdata: 16'hFFFF, uds: 1'b1, lds: 1'b1, exp_rd: 16'hFFFF};

    reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_addr = 14'h0; cpu_wdata = 16'h0; vid_req = 1'b0; vid_addr = 14'h0;
    idle_cycles(3);
    check("rst_dtack", cpu_dtack, 1'b0);
    check("rst_vid_ack", vid_ack, 1'b0);
    check("rst_we", ram_we, 1'b0);
    check("rst_ub_lb", {ram_ub, ram_lb}, 2'b00);
    check("rst_addr", ram_addr, 14'h0);
    check("rst_din", ram_din, 16'h0);
    check("rst_rdata", cpu_rdata, 16'h0);
    check("rst_vid_data", vid_data, 16'h0);
    reset = 1'b0;
    idle_cycles(1);

    // Table-driven writes with readback
    for (int i = 0; i < 5; i++) begin
      cpu_write(vecs[i].addr, vecs[i].wdata, vecs[i].uds, vecs[i].lds, i % 3);
      cpu_read(vecs[i].addr, 1);
      check("tbl_readback", cpu_rdata, vecs[i].exp_rd);
    end

    // Simultaneous video and CPU read: video first, then CPU despite vid_req staying high
    vid_addr = 14'h0010; cpu_addr = 14'h0020; cpu_rw = 1'b1;
    cpu_req = 1'b1; vid_req = 1'b1;
    order = ""; cdone = 1'b0; edge_no = 0; last_ack = -100; vdat = 16'h0; cdat = 16'h0;
    for (int i = 0; i < 30 && !cdone; i++) begin
      @(posedge clk); #1;
      edge_no++;
      if (vid_ack) begin
        order = {order, "V"};
        vdat = vid_data;
        last_ack = edge_no;
      end
      if (cpu_dtack) begin
        order = {order, "C"};
        cdat = cpu_rdata;
        cdone = 1'b1;
        cpu_req = 1'b0;
        vid_req = 1'b0;
      end
    end
    check("fair_order_vc", (order == "VC") ? 1 : 0, 1);
    check("fair_vid_data", vdat, 16'hAB34);
    check("fair_cpu_data", cdat, 16'h00EF);
    check("fair_cpu_gap", edge_no - last_ack, 3);
    idle_cycles(6);

    // Continuous video fetching: one ack every 3 cycles
    vaddrs[0] = 14'h0010; vaddrs[1] = 14'h0020; vaddrs[2] = 14'h3FFF;
    vaddrs[3] = 14'h0010; vaddrs[4] = 14'h0005; vaddrs[5] = 14'h0020;
    ack_cnt = 0; edge_no = 0; last_ack = 0; gap_bad = 0;
    va = vaddrs[0]; vid_addr = va; vid_req = 1'b1;
    for (int i = 0; i < 60 && ack_cnt < 6; i++) begin
      @(posedge clk); #1;
      edge_no++;
      if (vid_ack) begin
        check("b2b_vid_data", vid_data, model_rd(va));
        if (ack_cnt > 0 && edge_no - last_ack != 3) gap_bad++;
        last_ack = edge_no;
        ack_cnt++;
        if (ack_cnt < 6) begin
          va = vaddrs[ack_cnt];
          vid_addr = va;
        end
      end
    end
    vid_req = 1'b0;
    check("b2b_ack_count", ack_cnt, 6);
    check("b2b_ack_spacing", gap_bad, 0);
    idle_cycles(6);

    // Video request raised and dropped while CPU holds dtack is never serviced
    cpu_addr = 14'h0030; cpu_wdata = 16'h0F0F; cpu_uds = 1'b1; cpu_lds = 1'b1;
    cpu_rw = 1'b0; cpu_req = 1'b1;
    dt_seen = 0;
    for (int i = 0; i < 20 && dt_seen == 0; i++) begin
      @(posedge clk); #1;
      if (cpu_dtack) dt_seen = 1;
    end
    check("drop_wr_dtack", dt_seen, 1);
    model_wr(14'h0030, 16'h0F0F, 1'b1, 1'b1);
    vid_addr = 14'h0010; vid_req = 1'b1;
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (vid_ack) ack_seen++;
    end
    check("dropped_vid_not_served", ack_seen, 0);

    // Reset during the write access cycle
    cpu_addr = 14'h0100; cpu_wdata = 16'h7777; cpu_uds = 1'b1; cpu_lds = 1'b1;
    cpu_rw = 1'b0; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("rstw_we_before", ram_we, 1'b1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rstw_we_dropped", ram_we, 1'b0);
    check("rstw_no_dtack", cpu_dtack, 1'b0);
    check("rstw_addr_cleared", ram_addr, 14'h0);
    reset = 1'b0;
    dt_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (cpu_dtack) dt_seen++;
    end
    check("rstw_never_acked", dt_seen, 0);
    cpu_read(14'h0010, 0);

    // Random traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      logic [13:0] ra;
      ra = 14'h0200 + 14'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: cpu_write(ra, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
        1: cpu_read(ra, $urandom_range(0, 2));
        default: vid_fetch(ra);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
